shift_result_stage: RTL and testbench

- Registered stage directly downstream of the combinational 16-bit left shifter in the execute path.
- Captures the shifter output together with the original operand and shift amount.
- Derives zero and carry-out flags.
- Presents result plus flags to writeback through a valid/ready handshake, using a 2-entry skid buffer so backpressure never drops a result.

---
 rtl/shift_pkg.sv | 49 ++++
 rtl/shift_result_stage_if.sv | 38 +++
 rtl/shift_skid_buf.sv | 73 +++++++
 rtl/shift_result_stage.sv | 52 +++++
 tb/tb_shift_result_stage.sv | 173 +++++++++++++++++
 5 files changed

// File: rtl/shift_pkg.sv
// Shared types and flag helpers for the shift result stage.
// Optional SHIFT_OVERFLOW_EN adds an overflow flag to the payload.
package shift_pkg;

    localparam int SHIFT_DATA_W = 16;
    localparam int SHIFT_AMT_W  = 8;

    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        FULL  = 2'b11
    } buf_state_t;

    typedef struct packed {
        logic [SHIFT_DATA_W-1:0] result;
        logic                    zero;
        logic                    carry;
`ifdef SHIFT_OVERFLOW_EN
        logic                    ovf;
`endif
    } shift_res_t;

    // Last bit pushed past the MSB: value[DATA_W - amount] for 1..DATA_W, else 0.
    function automatic logic carry_out(input logic [SHIFT_DATA_W-1:0] value,
                                       input logic [SHIFT_AMT_W-1:0]  amount);
        logic c;
        c = 1'b0;
        for (int i = 1; i <= SHIFT_DATA_W; i++) begin
            if (amount == SHIFT_AMT_W'(i))
                c = value[SHIFT_DATA_W - i];
        end
        return c;
    endfunction

    // Any set bit of the operand discarded by the shift.
    function automatic logic ovf_out(input logic [SHIFT_DATA_W-1:0] value,
                                     input logic [SHIFT_AMT_W-1:0]  amount);
        logic o;
        o = 1'b0;
        if (amount > SHIFT_AMT_W'(SHIFT_DATA_W))
            o = |value;
        for (int i = 1; i <= SHIFT_DATA_W; i++) begin
            if (amount == SHIFT_AMT_W'(i))
                o = |(value >> (SHIFT_DATA_W - i));
        end
        return o;
    endfunction

endpackage

// File: rtl/shift_result_stage_if.sv
// Upstream shifter / downstream writeback bus for shift_result_stage.
// out_ovf exists only when SHIFT_OVERFLOW_EN is defined.
interface shift_result_stage_if #(
    parameter int DATA_W = shift_pkg::SHIFT_DATA_W,
    parameter int AMT_W  = shift_pkg::SHIFT_AMT_W
) ();

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_value;
    logic [AMT_W-1:0]  in_amount;
    logic [DATA_W-1:0] in_shifted;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_zero;
    logic              out_carry;
`ifdef SHIFT_OVERFLOW_EN
    logic              out_ovf;
`endif

    modport slave (
        input  in_valid, in_value, in_amount, in_shifted, out_ready,
        output in_ready, out_valid, out_result, out_zero, out_carry
`ifdef SHIFT_OVERFLOW_EN
        , output out_ovf
`endif
    );

    modport master (
        output in_valid, in_value, in_amount, in_shifted, out_ready,
        input  in_ready, out_valid, out_result, out_zero, out_carry
`ifdef SHIFT_OVERFLOW_EN
        , input out_ovf
`endif
    );

endinterface

// File: rtl/shift_skid_buf.sv
// Generic 2-entry valid/ready skid buffer; main entry drives the outputs,
// skid entry catches the push that lands while in_ready is still high.
module shift_skid_buf
    import shift_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    buf_state_t   state;
    logic [W-1:0] main_q;
    logic [W-1:0] skid_q;
    logic         push;
    logic         pop;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign out_data = main_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            main_q    <= '0;
            skid_q    <= '0;
        end else begin
            case (state)
                EMPTY: begin
                    if (push) begin
                        main_q    <= in_data;
                        out_valid <= 1'b1;
                        state     <= ONE;
                    end
                end
                ONE: begin
                    if (push && !pop) begin
                        skid_q   <= in_data;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (push && pop) begin
                        main_q <= in_data;
                    end else if (pop) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a pop can happen.
                    if (pop) begin
                        main_q   <= skid_q;
                        in_ready <= 1'b1;
                        state    <= ONE;
                    end
                end
                default: begin
                    state     <= EMPTY;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/shift_result_stage.sv
// Registered stage after the 16-bit left shifter: derives zero/carry
// (and ovf under SHIFT_OVERFLOW_EN) and hands results to writeback via a skid buffer.
module shift_result_stage
    import shift_pkg::*;
#(
    parameter int DATA_W = SHIFT_DATA_W,
    parameter int AMT_W  = SHIFT_AMT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    shift_result_stage_if.slave  bus
);

    shift_res_t        cap;
    shift_res_t        held;
    logic [DATA_W-1:0] shifted;
    logic [AMT_W-1:0]  amount;

    assign shifted = bus.in_shifted;
    assign amount  = bus.in_amount;

    always_comb begin
        cap        = '0;
        cap.result = shifted;
        cap.zero   = (shifted == '0);
        cap.carry  = carry_out(bus.in_value, amount);
`ifdef SHIFT_OVERFLOW_EN
        cap.ovf    = ovf_out(bus.in_value, amount);
`endif
    end

    shift_skid_buf #(
        .W($bits(shift_res_t))
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (bus.in_valid),
        .in_ready  (bus.in_ready),
        .in_data   (cap),
        .out_valid (bus.out_valid),
        .out_ready (bus.out_ready),
        .out_data  (held)
    );

    assign bus.out_result = held.result;
    assign bus.out_zero   = held.zero;
    assign bus.out_carry  = held.carry;
`ifdef SHIFT_OVERFLOW_EN
    assign bus.out_ovf    = held.ovf;
`endif

endmodule

// File: tb/tb_shift_result_stage.sv
// Directed bench for shift_result_stage; checks out_ovf too when SHIFT_OVERFLOW_EN is defined.
module tb_shift_result_stage;

    logic clk;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;

    shift_result_stage_if bus ();

    shift_result_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference: {result, zero, carry, ovf} from a wide shift.
    function automatic logic [18:0] model(input logic [15:0] v, input logic [7:0] a);
        logic [31:0] f;
        logic c, o;
        f = {16'h0, v} << a;
        c = (a >= 8'd1 && a <= 8'd16) ? f[16] : 1'b0;
        o = (a == 8'd0) ? 1'b0 : (a <= 8'd16) ? |f[31:16] : |v;
        return {f[15:0], f[15:0] == 16'h0, c, o};
    endfunction

    task automatic drive(input logic [15:0] v, input logic [7:0] a, input logic [15:0] sh);
        bus.in_valid   = 1'b1;
        bus.in_value   = v;
        bus.in_amount  = a;
        bus.in_shifted = sh;
    endtask

    task automatic chk_flags(input string tag, input logic [15:0] r, input logic z,
                             input logic c, input logic o);
        chk({tag, "_result"}, bus.out_result, r);
        chk({tag, "_zero"},   bus.out_zero,   z);
        chk({tag, "_carry"},  bus.out_carry,  c);
`ifdef SHIFT_OVERFLOW_EN
        chk({tag, "_ovf"},    bus.out_ovf,    o);
`else
        if (o === 1'bx) nchk += 0;
`endif
    endtask

    // One isolated transfer with out_ready high; expectations are hand values.
    task automatic xfer(input string tag, input logic [15:0] v, input logic [7:0] a,
                        input logic [15:0] r, input logic z, input logic c, input logic o);
        drive(v, a, r);
        step();
        bus.in_valid = 1'b0;
        chk({tag, "_valid"}, bus.out_valid, 1'b1);
        chk_flags(tag, r, z, c, o);
        step();
        chk({tag, "_drain"}, bus.out_valid, 1'b0);
    endtask

    initial begin
        logic [18:0] m;
        logic [15:0] v;
        logic [7:0]  a;

        rst_n          = 1'b0;
        bus.in_valid   = 1'b0;
        bus.in_value   = '0;
        bus.in_amount  = '0;
        bus.in_shifted = '0;
        bus.out_ready  = 1'b0;
        step();
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready",  bus.in_ready,  1'b1);
        chk_flags("rst", 16'h0000, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        step();

        bus.out_ready = 1'b1;
        xfer("single",   16'h8001, 8'd1,   16'h0002, 1'b0, 1'b1, 1'b1);
        xfer("amt16",    16'h0001, 8'd16,  16'h0000, 1'b1, 1'b1, 1'b1);
        xfer("amt0",     16'hFFFF, 8'd0,   16'hFFFF, 1'b0, 1'b0, 1'b0);
        xfer("amt200",   16'h1234, 8'd200, 16'h0000, 1'b1, 1'b0, 1'b1);
        xfer("amt17",    16'h00F0, 8'd17,  16'h0000, 1'b1, 1'b0, 1'b1);
        xfer("c000_2",   16'hC000, 8'd2,   16'h0000, 1'b1, 1'b1, 1'b1);
        xfer("ovf_4000", 16'h4000, 8'd2,   16'h0000, 1'b1, 1'b1, 1'b1);
        xfer("ovf_0fff", 16'h0FFF, 8'd4,   16'hFFF0, 1'b0, 1'b0, 1'b0);

        // Backpressure: two accepted, third stalls until downstream frees up.
        bus.out_ready = 1'b0;
        drive(16'h0003, 8'd2, 16'h000C);
        step();
        chk("bp1_in_ready", bus.in_ready, 1'b1);
        chk_flags("bp1", 16'h000C, 1'b0, 1'b0, 1'b0);
        drive(16'h0101, 8'd8, 16'h0100);
        step();
        chk("bp2_in_ready", bus.in_ready, 1'b0);
        chk("bp2_hold", bus.out_result, 16'h000C);
        drive(16'h7000, 8'd1, 16'hE000);
        step();
        chk("bp3_in_ready", bus.in_ready, 1'b0);
        chk_flags("bp3_hold", 16'h000C, 1'b0, 1'b0, 1'b0);
        bus.out_ready = 1'b1;
        step();
        chk("bp4_in_ready", bus.in_ready, 1'b1);
        chk_flags("bp4", 16'h0100, 1'b0, 1'b1, 1'b1);
        step();
        bus.in_valid = 1'b0;
        chk("bp5_valid", bus.out_valid, 1'b1);
        chk_flags("bp5", 16'hE000, 1'b0, 1'b0, 1'b0);
        step();
        chk("bp6_drain", bus.out_valid, 1'b0);

        // Streaming: one result per cycle, in_ready never drops.
        for (int i = 0; i < 50; i++) begin
            v = 16'($urandom);
            a = (i % 10 == 9) ? 8'($urandom_range(17, 255)) : 8'($urandom_range(0, 16));
            m = model(v, a);
            drive(v, a, m[18:3]);
            step();
            chk("stream_in_ready",  bus.in_ready,  1'b1);
            chk("stream_out_valid", bus.out_valid, 1'b1);
            chk_flags("stream", m[18:3], m[2], m[1], m[0]);
        end
        bus.in_valid = 1'b0;
        step();
        chk("stream_drain", bus.out_valid, 1'b0);

        // Invalid payloads must not load anything.
        drive(16'hFFFF, 8'd1, 16'hFFFE);
        bus.in_valid = 1'b0;
        step();
        chk("idle_valid", bus.out_valid, 1'b0);

        // Asynchronous reset with a full buffer.
        bus.out_ready = 1'b0;
        drive(16'h0011, 8'd4, 16'h0110);
        step();
        drive(16'h0022, 8'd4, 16'h0220);
        step();
        bus.in_valid = 1'b0;
        chk("full_in_ready", bus.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", bus.out_valid, 1'b0);
        chk("arst_in_ready",  bus.in_ready,  1'b1);
        chk_flags("arst", 16'h0000, 1'b0, 1'b0, 1'b0);
        step();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        step();
        step();
        chk("post_rst_valid", bus.out_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
        $finish;
    end

endmodule
